// File: rtl/mem_log_reader_pkg.sv
// mem_log_reader_pkg
// Shared definitions for the log readout sequencer: FSM state encoding,
// I/Q byte-lane positions inside a 16-bit log word, and the width of the
// read-latency counter.
package mem_log_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_FULL = 3'd1,
    S_ARM       = 3'd2,
    S_ADDR      = 3'd3,
    S_WAIT_DATA = 3'd4,
    S_SEND_HI   = 3'd5,
    S_SEND_LO   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  // I sample occupies [15:8], Q sample occupies [7:0].
  localparam int I_MSB = 15;
  localparam int Q_MSB = 7;

  // Latency counter holds READ_LAT (1..3).
  localparam int LAT_W = 2;

endpackage

// File: rtl/mem_log_reader.sv
// mem_log_reader
// Readout sequencer for the dual-BRAM sample logger. After a host dump
// request and once the logger reports full, it asserts read mode, sweeps
// every log address, captures each 16-bit I/Q word and streams it as two
// bytes (I first) over a valid/ready byte interface toward the UART TX path.
//
// Ports:
//   clk          system clock
//   i_rst        synchronous reset, active-high
//   i_start      one-cycle dump request (honoured only in IDLE)
//   i_mem_full   logger full flag
//   o_read_log   read-mode request to logger (ARM through DONE)
//   o_log_addr   read address to logger
//   i_log_data   read data from logger, valid READ_LAT clocks after address
//   o_tx_data    output byte
//   o_tx_valid   o_tx_data valid
//   i_tx_ready   consumer accepts byte when valid & ready
//   o_busy       high while a dump is in progress
//   o_done       one-cycle pulse after the last byte is accepted
module mem_log_reader
  import mem_log_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mem_full,
  output logic                  o_read_log,
  output logic [ADDR_WIDTH-1:0] o_log_addr,
  input  logic [DATA_WIDTH-1:0] i_log_data,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [LAT_W-1:0]      r_lat;
  logic [LAT_W-1:0]      w_lat_nxt;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [DATA_WIDTH-1:0] w_sample_nxt;

  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_read_log;
  logic                  r_busy;
  logic                  r_done;

  logic [7:0]            w_tx_data_nxt;
  logic                  w_tx_valid_nxt;
  logic                  w_read_log_nxt;
  logic                  w_busy_nxt;
  logic                  w_done_nxt;
  logic                  w_accept;

  assign w_accept = r_tx_valid & i_tx_ready;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_lat      <= '0;
      r_sample   <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_read_log <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_lat      <= w_lat_nxt;
      r_sample   <= w_sample_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_read_log <= w_read_log_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_lat_nxt    = r_lat;
    w_sample_nxt = r_sample;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_WAIT_FULL;
      end
      S_WAIT_FULL: begin
        if (i_mem_full) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_lat_nxt   = LAT_W'(READ_LAT);
        w_state_nxt = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        // Counter reaches zero one clock after data is valid, leaving a
        // clock of margin on the logger read path.
        if (r_lat == '0) begin
          w_sample_nxt = i_log_data;
          w_state_nxt  = S_SEND_HI;
        end else begin
          w_lat_nxt = r_lat - LAT_W'(1);
        end
      end
      S_SEND_HI: begin
        if (w_accept) w_state_nxt = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (w_accept) begin
          if (&r_addr) begin
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
            w_state_nxt = S_ADDR;
          end
        end
      end
      S_DONE: begin
        w_addr_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each one is valid in the
  // same cycle the FSM occupies the matching state. The byte lane uses the
  // next sample so the I byte is correct on the capture-to-SEND_HI edge.
  always_comb begin
    w_tx_valid_nxt = (w_state_nxt == S_SEND_HI) || (w_state_nxt == S_SEND_LO);
    w_read_log_nxt = w_state_nxt inside {S_ARM, S_ADDR, S_WAIT_DATA,
                                         S_SEND_HI, S_SEND_LO, S_DONE};
    w_busy_nxt     = (w_state_nxt != S_IDLE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_tx_data_nxt  = '0;
    if (w_state_nxt == S_SEND_HI) begin
      w_tx_data_nxt = w_sample_nxt[I_MSB -: 8];
    end else if (w_state_nxt == S_SEND_LO) begin
      w_tx_data_nxt = w_sample_nxt[Q_MSB -: 8];
    end
  end

  assign o_read_log = r_read_log;
  assign o_log_addr = r_addr;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_mem_log_reader.sv
// tb_mem_log_reader
// Two instances share stimulus: index 0 with READ_LAT=1, index 1 with
// READ_LAT=3, both with ADDR_WIDTH=3. Each has a logger model whose word k
// is {8'h10+k, 8'hA0+k}, returned READ_LAT clocks after the address.
// Expected bytes are queued per dump; a negedge monitor pops on every
// accepted byte and also checks stall stability, done/busy timing and
// word-rate timing.
module tb_mem_log_reader;

  logic       clk;
  logic       i_rst;
  logic       i_start;
  logic       i_mem_full;
  logic       i_tx_ready;

  logic       w_read_log [2];
  logic [2:0] w_addr     [2];
  logic [15:0] w_log_data [2];
  logic [7:0] w_tx_data  [2];
  logic       w_tx_valid [2];
  logic       w_busy     [2];
  logic       w_done     [2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_period = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int         done_cnt  [2];
  int         rl_cyc    [2];
  int         last_rise [2];
  logic       prev_stall[2];
  logic [7:0] prev_data [2];
  logic       prev_valid[2];
  logic       prev_rl   [2];
  logic       prev_done [2];
  logic       prev_rst;

  function automatic logic [15:0] word(input logic [2:0] k);
    logic [7:0] ib;
    logic [7:0] qb;
    ib = 8'h10 + {5'd0, k};
    qb = 8'hA0 + {5'd0, k};
    return {ib, qb};
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [3:0] r_pipe [3];

    mem_log_reader #(
      .ADDR_WIDTH(3),
      .DATA_WIDTH(16),
      .READ_LAT  (LAT)
    ) u_dut (
      .clk       (clk),
      .i_rst     (i_rst),
      .i_start   (i_start),
      .i_mem_full(i_mem_full),
      .o_read_log(w_read_log[g]),
      .o_log_addr(w_addr[g]),
      .i_log_data(w_log_data[g]),
      .o_tx_data (w_tx_data[g]),
      .o_tx_valid(w_tx_valid[g]),
      .i_tx_ready(i_tx_ready),
      .o_busy    (w_busy[g]),
      .o_done    (w_done[g])
    );

    // Logger: {read_mode, addr} pipeline; data only meaningful in read mode.
    always @(posedge clk) begin
      r_pipe[0] <= {w_read_log[g], w_addr[g]};
      r_pipe[1] <= r_pipe[0];
      r_pipe[2] <= r_pipe[1];
    end
    assign w_log_data[g] = r_pipe[LAT-1][3] ? word(r_pipe[LAT-1][2:0]) : 16'hDEAD;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h, required %0h (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int k = 0; k < 8; k++) begin
      logic [15:0] w;
      w = word(3'(k));
      q0.push_back(w[15:8]);
      q0.push_back(w[7:0]);
      q1.push_back(w[15:8]);
      q1.push_back(w[7:0]);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int c;
    c = 0;
    while ((done_cnt[0] < n || done_cnt[1] < n) && c < budget) begin
      tick();
      c++;
    end
    chk("dump_completes_in_budget", 0, 32'(c < budget), 32'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [7:0] e;
    bit         have;
    for (int d = 0; d < 2; d++) begin
      if (!i_rst) begin
        if (w_tx_valid[d] && i_tx_ready) begin
          have = 1'b0;
          e    = 8'h00;
          if (d == 0) begin
            if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
          end else begin
            if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
          end
          if (!have) begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte dut%0d: got %0h, required no byte (cycle %0d)",
                     d, w_tx_data[d], cyc);
          end else begin
            chk("tx_byte", d, 32'(w_tx_data[d]), 32'(e));
          end
        end
        if (prev_stall[d] && !prev_rst) begin
          chk("stall_valid_held", d, 32'(w_tx_valid[d]), 32'd1);
          chk("stall_data_held", d, 32'(w_tx_data[d]), 32'(prev_data[d]));
        end
        if (w_read_log[d] && !prev_rl[d]) begin
          rl_cyc[d]    = cyc;
          last_rise[d] = -1;
        end
        if (w_tx_valid[d] && !prev_valid[d]) begin
          if (chk_period) begin
            if (last_rise[d] < 0)
              chk("arm_to_first_byte", d, 32'(cyc - rl_cyc[d]), 32'(lat_of(d) + 3));
            else
              chk("word_period", d, 32'(cyc - last_rise[d]), 32'(lat_of(d) + 4));
          end
          last_rise[d] = cyc;
        end
        if (w_done[d]) begin
          done_cnt[d]++;
          chk("done_busy_high", d, 32'(w_busy[d]), 32'd1);
          chk("done_all_bytes_seen", d,
              32'((d == 0) ? q0.size() : q1.size()), 32'd0);
        end
        if (prev_done[d]) chk("busy_falls_after_done", d, 32'(w_busy[d]), 32'd0);
      end
      prev_stall[d] = w_tx_valid[d] && !i_tx_ready;
      prev_data[d]  = w_tx_data[d];
      prev_valid[d] = w_tx_valid[d];
      prev_rl[d]    = w_read_log[d];
      prev_done[d]  = w_done[d];
    end
    prev_rst = i_rst;
  end

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      done_cnt[d] = 0; rl_cyc[d] = 0; last_rise[d] = -1;
      prev_stall[d] = 1'b0; prev_data[d] = 8'h00; prev_valid[d] = 1'b0;
      prev_rl[d] = 1'b0; prev_done[d] = 1'b0;
    end
    prev_rst   = 1'b1;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_mem_full = 1'b0;
    i_tx_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_read_log", d, 32'(w_read_log[d]), 32'd0);
      chk("rst_addr", d, 32'(w_addr[d]), 32'd0);
      chk("rst_tx_valid", d, 32'(w_tx_valid[d]), 32'd0);
      chk("rst_tx_data", d, 32'(w_tx_data[d]), 32'd0);
      chk("rst_busy", d, 32'(w_busy[d]), 32'd0);
      chk("rst_done", d, 32'(w_done[d]), 32'd0);
    end
    tick();
    i_rst = 1'b0;
    tick();

    // Full-rate dump; extra start mid-dump and in instance 0's DONE cycle
    chk_period = 1'b1;
    i_mem_full = 1'b1;
    i_tx_ready = 1'b1;
    push_dump();
    pulse_start();
    repeat (10) tick();
    pulse_start();
    c = 0;
    while (!w_done[0] && c < 300) begin tick(); c++; end
    chk("dut0_done_seen", 0, 32'(w_done[0]), 32'd1);
    pulse_start();
    wait_done(1, 400);
    repeat (10) tick();
    for (int d = 0; d < 2; d++) begin
      chk("idle_after_dump_busy", d, 32'(w_busy[d]), 32'd0);
      chk("single_done_pulse", d, 32'(done_cnt[d]), 32'd1);
    end

    // Start before the logger is full
    i_mem_full = 1'b0;
    push_dump();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("no_read_before_full", d, 32'(w_read_log[d]), 32'd0);
        chk("no_byte_before_full", d, 32'(w_tx_valid[d]), 32'd0);
        chk("busy_while_waiting", d, 32'(w_busy[d]), 32'd1);
      end
      tick();
    end
    i_mem_full = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("read_log_before_sample", d, 32'(w_read_log[d]), 32'd0);
    tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("read_log_after_full", d, 32'(w_read_log[d]), 32'd1);
    wait_done(2, 400);
    tick();

    // Backpressure at roughly 30% ready
    chk_period = 1'b0;
    push_dump();
    pulse_start();
    c = 0;
    while ((done_cnt[0] < 3 || done_cnt[1] < 3) && c < 3000) begin
      i_tx_ready = ($urandom_range(0, 99) < 30);
      tick();
      c++;
    end
    chk("stalled_dump_completes", 0, 32'(c < 3000), 32'd1);
    i_tx_ready = 1'b1;
    repeat (3) tick();

    // Reset in SEND_LO of word 2, then a fresh dump from address 0
    chk_period = 1'b1;
    push_dump();
    pulse_start();
    c = 0;
    while (!(w_tx_valid[0] && w_tx_data[0] == 8'hA2) && c < 300) begin tick(); c++; end
    chk("reached_word2_lo", 0, 32'(w_tx_data[0]), 32'hA2);
    i_rst      = 1'b1;
    i_tx_ready = 1'b0;
    tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("midrst_tx_valid", d, 32'(w_tx_valid[d]), 32'd0);
      chk("midrst_read_log", d, 32'(w_read_log[d]), 32'd0);
      chk("midrst_busy", d, 32'(w_busy[d]), 32'd0);
    end
    q0.delete();
    q1.delete();
    tick();
    i_rst      = 1'b0;
    i_tx_ready = 1'b1;
    tick();
    chk("idle_addr_after_rst", 0, 32'(w_addr[0]), 32'd0);
    push_dump();
    pulse_start();
    wait_done(4, 400);
    repeat (5) tick();
    for (int d = 0; d < 2; d++) chk("final_done_count", d, 32'(done_cnt[d]), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
